fetch_unit: RTL and testbench

Instruction fetch stage, directly upstream of the decoder. It holds the PC and issues 32-bit instruction-memory reads, up to DEPTH in flight. Returned instructions are buffered with their PC in a small FIFO, which presents one {instr, pc} pair per handshake to the decoder. A branch/jump redirect from execute flushes the buffer and the in-flight fetches.

---
 rtl/fetch_unit.sv | 143 ++++++++++++++
 tb/tb_fetch_unit.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps up to DEPTH instruction-memory
// reads in flight, and buffers returned words with their PC in a small FIFO
// that feeds the decoder. A redirect from execute empties the buffer and marks
// every in-flight response to be thrown away when it arrives.
module fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          DEPTH    = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_imem_req_valid,
    input  logic        i_imem_req_ready,
    output logic [63:0] o_imem_addr,
    input  logic        i_imem_rsp_valid,
    input  logic [31:0] i_imem_rsp_data,
    input  logic        i_redirect,
    input  logic [63:0] i_redirect_pc,
    output logic        o_instr_valid,
    input  logic        i_instr_ready,
    output logic [31:0] o_instr,
    output logic [63:0] o_instr_pc
);

    localparam int PW = $clog2(DEPTH);
    // Counters are wide enough to hold outstanding + count (up to 2*DEPTH).
    localparam int CW = $clog2(DEPTH) + 2;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } entry_t;

    logic [63:0]   pc_q, pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    entry_t        fifo_q [DEPTH];

    logic          req_valid;
    logic          req_fire;
    logic          rsp_live;
    logic          rsp_drop;
    logic          push;
    logic          pop;
    logic          instr_valid;
    logic [CW-1:0] credit_used;
    logic [63:0]   tail_pc;

    // Handshake decode, credit check and next-state computation.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
        credit_used   = outstanding_q + count_q;
        req_valid     = !i_rst && !i_redirect && (credit_used < CW'(DEPTH));
        req_fire      = req_valid && i_imem_req_ready;
        // A response with nothing outstanding can only be stale; ignore it.
        rsp_live      = i_imem_rsp_valid && (outstanding_q != '0);
        rsp_drop      = (discard_q != '0);
        // Responses return in order, so the oldest request's PC sits
        // 4*outstanding bytes behind the next fetch address.
        tail_pc       = pc_q - (64'(outstanding_q) << 2);
        push          = rsp_live && !rsp_drop && !i_redirect;
        instr_valid   = (count_q != '0) && !i_redirect && !i_rst;
        pop           = instr_valid && i_instr_ready;

        pc_d          = pc_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        count_d       = count_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;

        if (req_fire) begin
            pc_d = pc_q + 64'd4;
        end
        if (req_fire) begin
            outstanding_d = outstanding_d + CW'(1);
        end
        if (rsp_live) begin
            outstanding_d = outstanding_d - CW'(1);
        end

        if (i_redirect) begin
            // Everything still in flight belongs to the old path.
            pc_d      = {i_redirect_pc[63:2], 2'b00};
            discard_d = outstanding_d;
            count_d   = '0;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
        end else begin
            if (rsp_live && rsp_drop) begin
                discard_d = discard_q - CW'(1);
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (i_rst) begin
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else begin
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            count_q       <= count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
        end
    end

    // FIFO storage: written on push, contents qualified by count.
    always_ff @(posedge i_clk) begin
        // NOTE: the storage array is deliberately not reset; count_q alone decides which entries are meaningful.
        if (push) begin
            fifo_q[wr_ptr_q] <= '{pc: tail_pc, instr: i_imem_rsp_data};
        end
    end

    assign o_imem_req_valid = req_valid;
    assign o_imem_addr      = pc_q;
    assign o_instr_valid    = instr_valid;
    assign o_instr          = fifo_q[rd_ptr_q].instr;
    assign o_instr_pc       = fifo_q[rd_ptr_q].pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit (RESET_PC=0x1000, DEPTH=4) with an
// in-order instruction-memory model of configurable latency.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        o_imem_req_valid;
    logic        i_imem_req_ready = 1'b1;
    logic [63:0] o_imem_addr;
    logic        i_imem_rsp_valid = 1'b0;
    logic [31:0] i_imem_rsp_data = '0;
    logic        i_redirect = 1'b0;
    logic [63:0] i_redirect_pc = '0;
    logic        o_instr_valid;
    logic        i_instr_ready = 1'b0;
    logic [31:0] o_instr;
    logic [63:0] o_instr_pc;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int mem_lat = 1;

    typedef struct {
        logic [63:0] addr;
        int          due;
    } mreq_t;
    mreq_t mq[$];

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(64'h1000), .DEPTH(4)) dut (
        .i_clk            (clk),
        .i_rst            (i_rst),
        .o_imem_req_valid (o_imem_req_valid),
        .i_imem_req_ready (i_imem_req_ready),
        .o_imem_addr      (o_imem_addr),
        .i_imem_rsp_valid (i_imem_rsp_valid),
        .i_imem_rsp_data  (i_imem_rsp_data),
        .i_redirect       (i_redirect),
        .i_redirect_pc    (i_redirect_pc),
        .o_instr_valid    (o_instr_valid),
        .i_instr_ready    (i_instr_ready),
        .o_instr          (o_instr),
        .o_instr_pc       (o_instr_pc)
    );

    // Instruction word the memory model returns for a given address.
    function automatic logic [31:0] word_of(input logic [63:0] a);
        return a[31:0] ^ 32'hC0DE_0000;
    endfunction

    // One clock: record an accepted request, advance, then drive the memory response.
    task automatic tick();
        if (o_imem_req_valid && i_imem_req_ready)
            mq.push_back('{addr: o_imem_addr, due: cyc + mem_lat});
        @(posedge clk);
        #1;
        cyc++;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            i_imem_rsp_valid = 1'b1;
            i_imem_rsp_data  = word_of(mq[0].addr);
            void'(mq.pop_front());
        end else begin
            i_imem_rsp_valid = 1'b0;
            i_imem_rsp_data  = '0;
        end
        #1;
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        i_redirect = 1'b0;
        i_instr_ready = 1'b0;
        i_imem_req_ready = 1'b1;
        #1;
        tick();
        tick();
        mq.delete();
        i_imem_rsp_valid = 1'b0;
        i_rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (o_imem_req_valid !== 1'b0 || o_instr_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_valids: req_valid=%b instr_valid=%b want 0/0", o_imem_req_valid, o_instr_valid);
            end
            tick();
        end
        mq.delete();
        i_rst = 1'b0;
        #1;
        n_cmp++;
        if (o_imem_req_valid !== 1'b1 || o_imem_addr !== 64'h1000) begin
            n_bad++;
            $display("FAIL reset_first_req: valid=%b addr=%h want 1/1000", o_imem_req_valid, o_imem_addr);
        end
        n_cmp++;
        if (o_instr_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_fifo_empty: instr_valid=%b want 0", o_instr_valid);
        end
    endtask

    task automatic test_stream();
        logic [63:0] exp_pc = 64'h1000;
        logic [63:0] exp_req = 64'h1000;
        do_reset();
        mem_lat = 1;
        i_instr_ready = 1'b1;
        #1;
        for (int k = 0; k < 16; k++) begin
            n_cmp++;
            if (o_imem_req_valid !== 1'b1 || o_imem_addr !== exp_req) begin
                n_bad++;
                $display("FAIL stream_req k=%0d: valid=%b addr=%h want 1/%h", k, o_imem_req_valid, o_imem_addr, exp_req);
            end
            exp_req = exp_req + 64'd4;
            n_cmp++;
            if (k < 2) begin
                if (o_instr_valid !== 1'b0) begin
                    n_bad++;
                    $display("FAIL stream_fill k=%0d: instr_valid=%b want 0", k, o_instr_valid);
                end
            end else begin
                if (o_instr_valid !== 1'b1 || o_instr_pc !== exp_pc || o_instr !== word_of(exp_pc)) begin
                    n_bad++;
                    $display("FAIL stream_out k=%0d: valid=%b pc=%h instr=%h want 1/%h/%h", k, o_instr_valid, o_instr_pc, o_instr, exp_pc, word_of(exp_pc));
                end
                exp_pc = exp_pc + 64'd4;
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] exp_req = 64'h1000;
        logic [63:0] exp_pc  = 64'h1000;
        int n_req = 0;
        do_reset();
        mem_lat = 1;
        for (int k = 0; k < 10; k++) begin
            if (o_imem_req_valid && i_imem_req_ready) begin
                n_cmp++;
                if (o_imem_addr !== exp_req) begin
                    n_bad++;
                    $display("FAIL hold_req_addr: addr=%h want %h", o_imem_addr, exp_req);
                end
                exp_req = exp_req + 64'd4;
                n_req++;
            end
            if (k >= 2) begin
                n_cmp++;
                if (o_instr_valid !== 1'b1 || o_instr_pc !== 64'h1000 || o_instr !== word_of(64'h1000)) begin
                    n_bad++;
                    $display("FAIL hold_head k=%0d: valid=%b pc=%h instr=%h want 1/1000/%h", k, o_instr_valid, o_instr_pc, o_instr, word_of(64'h1000));
                end
            end
            tick();
        end
        n_cmp++;
        if (n_req != 4 || o_imem_req_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL hold_credit: requests=%0d req_valid=%b want 4/0", n_req, o_imem_req_valid);
        end
        i_instr_ready = 1'b1;
        #1;
        for (int k = 0; k < 8; k++) begin
            n_cmp++;
            if (o_instr_valid !== 1'b1 || o_instr_pc !== exp_pc || o_instr !== word_of(exp_pc)) begin
                n_bad++;
                $display("FAIL drain k=%0d: valid=%b pc=%h want 1/%h", k, o_instr_valid, o_instr_pc, exp_pc);
            end
            exp_pc = exp_pc + 64'd4;
            tick();
        end
    endtask

    task automatic test_redirect_inflight();
        bit found = 0;
        do_reset();
        mem_lat = 3;
        i_instr_ready = 1'b1;
        tick();
        tick();
        i_redirect = 1'b1;
        i_redirect_pc = 64'h2002;
        #1;
        n_cmp++;
        if (o_imem_req_valid !== 1'b0 || o_instr_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL redir_gate: req_valid=%b instr_valid=%b want 0/0", o_imem_req_valid, o_instr_valid);
        end
        tick();
        i_redirect = 1'b0;
        #1;
        n_cmp++;
        if (o_imem_req_valid !== 1'b1 || o_imem_addr !== 64'h2000) begin
            n_bad++;
            $display("FAIL redir_addr: valid=%b addr=%h want 1/2000", o_imem_req_valid, o_imem_addr);
        end
        for (int k = 0; k < 20 && !found; k++) begin
            if (o_instr_valid) begin
                found = 1;
                n_cmp++;
                if (o_instr_pc !== 64'h2000 || o_instr !== word_of(64'h2000)) begin
                    n_bad++;
                    $display("FAIL redir_first_pc: pc=%h instr=%h want 2000/%h", o_instr_pc, o_instr, word_of(64'h2000));
                end
            end else begin
                tick();
            end
        end
        if (!found) begin
            n_cmp++;
            n_bad++;
            $display("FAIL redir_timeout: no instruction within 20 cycles");
        end
    endtask

    task automatic test_redirect_collision();
        bit found = 0;
        do_reset();
        mem_lat = 1;
        tick();
        tick();
        i_redirect = 1'b1;
        i_redirect_pc = 64'h5000;
        #1;
        n_cmp++;
        if (i_imem_rsp_valid !== 1'b1 || o_instr_valid !== 1'b0 || o_imem_req_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL coll_cycle: rsp=%b instr_valid=%b req_valid=%b want 1/0/0", i_imem_rsp_valid, o_instr_valid, o_imem_req_valid);
        end
        tick();
        i_redirect = 1'b0;
        #1;
        n_cmp++;
        if (o_instr_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL coll_flushed: instr_valid=%b pc=%h want 0", o_instr_valid, o_instr_pc);
        end
        n_cmp++;
        if (o_imem_req_valid !== 1'b1 || o_imem_addr !== 64'h5000) begin
            n_bad++;
            $display("FAIL coll_addr: valid=%b addr=%h want 1/5000", o_imem_req_valid, o_imem_addr);
        end
        i_instr_ready = 1'b1;
        #1;
        for (int k = 0; k < 10 && !found; k++) begin
            if (o_instr_valid) begin
                found = 1;
                n_cmp++;
                if (o_instr_pc !== 64'h5000) begin
                    n_bad++;
                    $display("FAIL coll_first_pc: pc=%h want 5000", o_instr_pc);
                end
            end else begin
                tick();
            end
        end
        if (!found) begin
            n_cmp++;
            n_bad++;
            $display("FAIL coll_timeout: no instruction within 10 cycles");
        end
    endtask

    task automatic test_req_stall();
        do_reset();
        mem_lat = 1;
        i_imem_req_ready = 1'b0;
        i_redirect = 1'b1;
        i_redirect_pc = 64'h3000;
        #1;
        tick();
        i_redirect = 1'b0;
        #1;
        for (int k = 0; k < 5; k++) begin
            n_cmp++;
            if (o_imem_req_valid !== 1'b1 || o_imem_addr !== 64'h3000) begin
                n_bad++;
                $display("FAIL stall_hold k=%0d: valid=%b addr=%h want 1/3000", k, o_imem_req_valid, o_imem_addr);
            end
            tick();
        end
        i_imem_req_ready = 1'b1;
        #1;
        n_cmp++;
        if (o_imem_req_valid !== 1'b1 || o_imem_addr !== 64'h3000) begin
            n_bad++;
            $display("FAIL stall_release: valid=%b addr=%h want 1/3000", o_imem_req_valid, o_imem_addr);
        end
        tick();
        n_cmp++;
        if (o_imem_req_valid !== 1'b1 || o_imem_addr !== 64'h3004) begin
            n_bad++;
            $display("FAIL stall_next: valid=%b addr=%h want 1/3004", o_imem_req_valid, o_imem_addr);
        end
    endtask

    task automatic test_pc_wrap_and_reset();
        logic [63:0] wrap_exp [4];
        int req_idx = 0;
        int out_idx = 0;
        wrap_exp[0] = 64'hFFFF_FFFF_FFFF_FFF8;
        wrap_exp[1] = 64'hFFFF_FFFF_FFFF_FFFC;
        wrap_exp[2] = 64'h0;
        wrap_exp[3] = 64'h4;
        do_reset();
        mem_lat = 1;
        i_instr_ready = 1'b1;
        i_redirect = 1'b1;
        i_redirect_pc = 64'hFFFF_FFFF_FFFF_FFF8;
        #1;
        tick();
        i_redirect = 1'b0;
        #1;
        for (int k = 0; k < 6; k++) begin
            if (o_imem_req_valid && i_imem_req_ready && req_idx < 4) begin
                n_cmp++;
                if (o_imem_addr !== wrap_exp[req_idx]) begin
                    n_bad++;
                    $display("FAIL wrap_req %0d: addr=%h want %h", req_idx, o_imem_addr, wrap_exp[req_idx]);
                end
                req_idx++;
            end
            if (o_instr_valid && out_idx < 3) begin
                n_cmp++;
                if (o_instr_pc !== wrap_exp[out_idx]) begin
                    n_bad++;
                    $display("FAIL wrap_out %0d: pc=%h want %h", out_idx, o_instr_pc, wrap_exp[out_idx]);
                end
                out_idx++;
            end
            tick();
        end
        n_cmp++;
        if (req_idx != 4 || out_idx != 3) begin
            n_bad++;
            $display("FAIL wrap_progress: requests=%0d outputs=%0d want 4/3", req_idx, out_idx);
        end
        // Mid-stream reset: FIFO holds entries here, valids must still drop.
        i_rst = 1'b1;
        #1;
        n_cmp++;
        if (o_imem_req_valid !== 1'b0 || o_instr_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL midrst_gate: req_valid=%b instr_valid=%b want 0/0", o_imem_req_valid, o_instr_valid);
        end
        tick();
        n_cmp++;
        if (o_imem_req_valid !== 1'b0 || o_instr_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL midrst_held: req_valid=%b instr_valid=%b want 0/0", o_imem_req_valid, o_instr_valid);
        end
        mq.delete();
        i_imem_rsp_valid = 1'b0;
        i_rst = 1'b0;
        #1;
        n_cmp++;
        if (o_imem_req_valid !== 1'b1 || o_imem_addr !== 64'h1000 || o_instr_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL midrst_restart: valid=%b addr=%h instr_valid=%b want 1/1000/0", o_imem_req_valid, o_imem_addr, o_instr_valid);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_inflight();
        test_redirect_collision();
        test_req_stall();
        test_pc_wrap_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
